bcd_scan_counter: RTL and testbench

//  NDIG-digit synchronous BCD up/down counter with a time-multiplexed digit scanner.

---
 rtl/bcd_pkg.sv | 28 ++
 rtl/bcd_digit.sv | 61 ++++++
 rtl/bcd_scan_counter.sv | 183 ++++++++++++++++++
 tb/tb_bcd_scan_counter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared BCD types and helpers for the scanned BCD counter.
//   bcd_t        : one BCD digit nibble
//   BCD_MAX      : largest legal digit value (9)
//   BCD_BLANK    : code the downstream bcd2seven decoder renders as blank
//   bcd_sanitize : forces any non-BCD nibble (>9) to 0
// -----------------------------------------------------------------------------
package bcd_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX   = 4'd9;
    localparam bcd_t BCD_BLANK = 4'hF;

    // Non-BCD codes collapse to 0 so a bad load can never leave a digit stuck
    // outside the 0..9 cycle.
    function automatic bcd_t bcd_sanitize(input bcd_t nibble);
        bcd_t res;
        if (nibble > BCD_MAX) begin
            res = 4'd0;
        end else begin
            res = nibble;
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
// One BCD digit up/down counter; chained through co/bo to build a multi-digit
// counter.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   inc, dec       : step up / step down this cycle (never both in practice)
//   ld, ld_val     : synchronous load, value sanitised to BCD
//   clr            : synchronous clear, highest priority
//   q              : registered digit value
//   co             : carry out, inc while q==9 (combinational)
//   bo             : borrow out, dec while q==0 (combinational)
// -----------------------------------------------------------------------------
module bcd_digit
    import bcd_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    input  logic ld,
    input  bcd_t ld_val,
    input  logic clr,
    output bcd_t q,
    output logic co,
    output logic bo
);

    bcd_t q_q;
    bcd_t q_d;

    // Next digit value: clr > ld > inc > dec.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = 4'd0;
        end else if (ld) begin
            q_d = bcd_sanitize(ld_val);
        end else if (inc) begin
            q_d = (q_q == BCD_MAX) ? 4'd0 : (q_q + 4'd1);
        end else if (dec) begin
            q_d = (q_q == 4'd0) ? BCD_MAX : (q_q - 4'd1);
        end else begin
            q_d = q_q;
        end
    end

    // Digit state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q  = q_q;
    assign co = inc & (q_q == BCD_MAX);
    assign bo = dec & (q_q == 4'd0);

endmodule

// File: rtl/bcd_scan_counter.sv
// -----------------------------------------------------------------------------
// bcd_scan_counter
// NDIG-digit BCD up/down counter with a time-multiplexed digit scanner feeding
// a bcd2seven decoder.
// Parameters:
//   NDIG     : number of digits (2..8)
//   SCAN_DIV : clk cycles per scan slot (>=2)
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en, up     : count enable and direction
//   clr        : synchronous clear (beats load and en)
//   load       : synchronous parallel load of load_val (beats en)
//   load_val   : load value, digit0 in [3:0], non-BCD nibbles load as 0
//   count      : registered count, digit0 in [3:0]
//   carry      : one-cycle pulse on wrap in either direction
//   bcd_out    : registered nibble of the scanned digit
//   dig_an_n   : registered active-low one-cold digit enable
// Configuration macro:
//   LEADING_ZERO_BLANK_EN : when defined, leading zero digits (except digit0)
//                           are shown as BCD_BLANK.
// -----------------------------------------------------------------------------
module bcd_scan_counter
    import bcd_pkg::*;
#(
    parameter int NDIG     = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              up,
    input  logic              clr,
    input  logic              load,
    input  logic [4*NDIG-1:0] load_val,
    output logic [4*NDIG-1:0] count,
    output logic              carry,
    output logic [3:0]        bcd_out,
    output logic [NDIG-1:0]   dig_an_n
);

    localparam int PSC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);

    bcd_t              digit_s [NDIG];
    logic [NDIG-1:0]   inc_s;
    logic [NDIG-1:0]   dec_s;
    logic [NDIG-1:0]   co_s;
    logic [NDIG-1:0]   bo_s;
    logic              step_s;

    logic              carry_q;
    logic              carry_d;
    logic [PSC_W-1:0]  psc_q;
    logic [PSC_W-1:0]  psc_d;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  idx_d;
    logic [3:0]        bcd_out_q;
    logic [3:0]        bcd_out_d;
    logic [NDIG-1:0]   dig_an_n_q;
    logic [NDIG-1:0]   dig_an_n_d;
    bcd_t              sel_s;

    // Counting only happens when neither clr nor load claims the cycle.
    assign step_s = en & ~clr & ~load;

    genvar g;
    generate
        for (g = 0; g < NDIG; g++) begin : g_digit
            if (g == 0) begin : g_lsd
                assign inc_s[g] = step_s & up;
                assign dec_s[g] = step_s & ~up;
            end else begin : g_upper
                assign inc_s[g] = co_s[g-1];
                assign dec_s[g] = bo_s[g-1];
            end

            bcd_digit u_digit (
                .clk    (clk),
                .rst_n  (rst_n),
                .inc    (inc_s[g]),
                .dec    (dec_s[g]),
                .ld     (load),
                .ld_val (load_val[4*g +: 4]),
                .clr    (clr),
                .q      (digit_s[g]),
                .co     (co_s[g]),
                .bo     (bo_s[g])
            );

            assign count[4*g +: 4] = digit_s[g];
        end
    endgenerate

    // Carry pulses only when the most significant digit wraps; step_s gating
    // already makes clr/load force it low.
    always_comb begin
        carry_d = co_s[NDIG-1] | bo_s[NDIG-1];
    end

    // Free-running prescaler and scan index, independent of count controls.
    always_comb begin
        psc_d = psc_q;
        idx_d = idx_q;
        if (psc_q == PSC_LAST) begin
            psc_d = {PSC_W{1'b0}};
            idx_d = (idx_q == IDX_LAST) ? {IDX_W{1'b0}} : (idx_q + {{(IDX_W-1){1'b0}}, 1'b1});
        end else begin
            psc_d = psc_q + {{(PSC_W-1){1'b0}}, 1'b1};
            idx_d = idx_q;
        end
    end

    // Select the scanned digit (and optionally blank it) from current state.
    always_comb begin
        sel_s = 4'd0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_s = digit_s[i];
            end else begin
                sel_s = sel_s;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic blank_s;

    // A digit above digit0 is blank when it and every higher digit are zero.
    always_comb begin
        blank_s = 1'b0;
        for (int i = 1; i < NDIG; i++) begin
            if (idx_q == IDX_W'(i)) begin
                blank_s = 1'b1;
                for (int j = i; j < NDIG; j++) begin
                    blank_s = blank_s & (digit_s[j] == 4'd0);
                end
            end else begin
                blank_s = blank_s;
            end
        end
    end

    // Output nibble with blanking applied.
    always_comb begin
        bcd_out_d = blank_s ? BCD_BLANK : sel_s;
    end
`else
    // Output nibble, every digit shown.
    always_comb begin
        bcd_out_d = sel_s;
    end
`endif

    // One-cold digit enable for the current index.
    always_comb begin
        dig_an_n_d = ~(NDIG'(1) << idx_q);
    end

    // Carry, scanner state and registered display outputs; nibble and enable
    // share one edge so two digits are never lit together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q    <= 1'b0;
            psc_q      <= {PSC_W{1'b0}};
            idx_q      <= {IDX_W{1'b0}};
            bcd_out_q  <= 4'h0;
            dig_an_n_q <= ~(NDIG'(1));
        end else begin
            carry_q    <= carry_d;
            psc_q      <= psc_d;
            idx_q      <= idx_d;
            bcd_out_q  <= bcd_out_d;
            dig_an_n_q <= dig_an_n_d;
        end
    end

    assign carry    = carry_q;
    assign bcd_out  = bcd_out_q;
    assign dig_an_n = dig_an_n_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_scan_counter
// Directed self-checking bench for bcd_scan_counter (NDIG=4, SCAN_DIV=4).
// Expected display words depend on LEADING_ZERO_BLANK_EN.
// -----------------------------------------------------------------------------
module tb_bcd_scan_counter;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        up;
    logic        clr;
    logic        load;
    logic [15:0] load_val;
    logic [15:0] count;
    logic        carry;
    logic [3:0]  bcd_out;
    logic [3:0]  dig_an_n;

    int n_checks;
    int n_errors;

    bcd_scan_counter #(
        .NDIG     (4),
        .SCAN_DIV (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up       (up),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .carry    (carry),
        .bcd_out  (bcd_out),
        .dig_an_n (dig_an_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset between edges, load cnt on the first edge after release, then
    // walk 20 edges checking scanner order and the displayed word exp_word
    // ({digit3..digit0} as seen on bcd_out).
    task automatic scan_check(input string tag, input logic [15:0] cnt, input logic [15:0] exp_word);
        int j;
        logic [3:0] exp_dig;
        logic [15:0] w;
        w = exp_word;
        en = 1'b0; clr = 1'b0;
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        load = 1'b1; load_val = cnt;
        for (int k = 1; k <= 20; k++) begin
            step();
            load = 1'b0;
            if (k == 1) begin
                check_eq({tag, "_an_first"}, {12'd0, dig_an_n}, 16'h000E);
            end else begin
                j = ((k - 1) / 4) % 4;
                exp_dig = ~(4'd1 << j);
                check_eq({tag, "_an"}, {12'd0, dig_an_n}, {12'd0, exp_dig});
                check_eq({tag, "_bcd"}, {12'd0, bcd_out}, {12'd0, w[4*j +: 4]});
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; load_val = 16'h0000;
        #12 rst_n = 1'b1;

        // 1: asynchronous reset mid-count, outputs clear before any edge.
        load = 1'b1; load_val = 16'h0357;
        step();
        load = 1'b0; en = 1'b1; up = 1'b1;
        repeat (6) step();
        check_eq("pre_reset_count", count, 16'h0363);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_count", count, 16'h0000);
        check_eq("rst_carry", {15'd0, carry}, 16'h0000);
        check_eq("rst_bcd", {12'd0, bcd_out}, 16'h0000);
        check_eq("rst_an", {12'd0, dig_an_n}, 16'h000E);
        en = 1'b0;
        #2 rst_n = 1'b1;

        // 2: increments across a digit boundary.
        load = 1'b1; load_val = 16'h0998;
        step();
        load = 1'b0;
        check_eq("load_0998", count, 16'h0998);
        en = 1'b1; up = 1'b1;
        step();
        check_eq("inc_0999", count, 16'h0999);
        check_eq("inc_0999_carry", {15'd0, carry}, 16'h0000);
        step();
        check_eq("inc_1000", count, 16'h1000);
        check_eq("inc_1000_carry", {15'd0, carry}, 16'h0000);
        step();
        check_eq("inc_1001", count, 16'h1001);
        en = 1'b0;

        // 3: wrap up and down with single-cycle carry.
        load = 1'b1; load_val = 16'h9999;
        step();
        load = 1'b0; en = 1'b1; up = 1'b1;
        step();
        check_eq("wrap_up", count, 16'h0000);
        check_eq("wrap_up_carry", {15'd0, carry}, 16'h0001);
        up = 1'b0;
        step();
        check_eq("wrap_dn", count, 16'h9999);
        check_eq("wrap_dn_carry", {15'd0, carry}, 16'h0001);
        en = 1'b0;
        step();
        check_eq("hold", count, 16'h9999);
        check_eq("carry_drop", {15'd0, carry}, 16'h0000);
        up = 1'b0; en = 1'b1;
        step();
        check_eq("dec_9998", count, 16'h9998);
        en = 1'b0;

        // 4: priority clr > load > en, then sanitised load.
        load = 1'b1; load_val = 16'h1234;
        step();
        check_eq("load_1234", count, 16'h1234);
        clr = 1'b1; load = 1'b1; en = 1'b1; up = 1'b1; load_val = 16'h5678;
        step();
        check_eq("clr_prio", count, 16'h0000);
        check_eq("clr_carry", {15'd0, carry}, 16'h0000);
        clr = 1'b0; load = 1'b1; en = 1'b1; load_val = 16'h9A3C;
        step();
        check_eq("load_prio_sanitize", count, 16'h9030);
        load = 1'b0; en = 1'b0;

        // 5/6: scanner order and displayed digits.
        scan_check("scan_4321", 16'h4321, 16'h4321);
`ifdef LEADING_ZERO_BLANK_EN
        scan_check("scan_0005", 16'h0005, 16'hFFF5);
        scan_check("scan_0000", 16'h0000, 16'hFFF0);
        scan_check("scan_0405", 16'h0405, 16'hF405);
`else
        scan_check("scan_0005", 16'h0005, 16'h0005);
        scan_check("scan_0000", 16'h0000, 16'h0000);
        scan_check("scan_0405", 16'h0405, 16'h0405);
`endif
        check_eq("scan_count_kept", count, 16'h0405);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
